// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with an input FIFO and a fractional baud
// accumulator. Bytes are accepted on a valid/ready handshake, queued, and
// shifted out LSB first at 16 oversample ticks per bit.
//
// Ports:
//   i_clk          single clock
//   i_rst_n        asynchronous active-low reset
//   i_tx_byte      byte to enqueue
//   i_tx_valid     i_tx_byte is valid this cycle
//   o_tx_ready     FIFO not full, a write is accepted
//   o_tx           registered serial line, idle high
//   o_busy         FIFO non-empty or a frame in progress
//   o_fifo_count   bytes queued, excluding the one being shifted
//
// state    | meaning
// ---------+------------------------------------------------------------
// st_idle  | line high, waiting for a tick with the FIFO non-empty
// st_start | start bit (line low) for 16 ticks
// st_data  | data bit sh[0] for 16 ticks each, 8 bits LSB first
// st_stop  | stop bit (line high) for 16 ticks, then next byte or idle

module uart_tx #(
  parameter int unsigned baud_acc_width  = 11,
  parameter int unsigned baud_acc_incr   = 151,
  parameter int unsigned fifo_depth_log2 = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_tx_byte,
  input  logic                       i_tx_valid,
  output logic                       o_tx_ready,
  output logic                       o_tx,
  output logic                       o_busy,
  output logic [fifo_depth_log2:0]   o_fifo_count
);

  localparam int unsigned fifo_depth = 1 << fifo_depth_log2;
  localparam logic [baud_acc_width:0] acc_incr = baud_acc_incr[baud_acc_width:0];
  localparam logic [fifo_depth_log2:0] count_full = {1'b1, {fifo_depth_log2{1'b0}}};

  typedef enum logic [1:0] {
    st_idle,
    st_start,
    st_data,
    st_stop
  } state_t;

  // baud accumulator; the registered carry is the oversample tick
  logic [baud_acc_width-1:0] acc;
  logic                      tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      {tick, acc} <= {1'b0, acc} + acc_incr;
    end
  end

  // FIFO
  logic [7:0]                 mem [fifo_depth];
  logic [fifo_depth_log2-1:0] wptr;
  logic [fifo_depth_log2-1:0] rptr;
  logic [fifo_depth_log2:0]   count;
  logic                       push;
  logic                       pop;
  logic                       fifo_nonempty;

  // ready depends only on the current count: a full FIFO refuses a write
  // even on a cycle where the serialiser pops
  assign o_tx_ready    = (count < count_full);
  assign push          = i_tx_valid && o_tx_ready;
  assign fifo_nonempty = (count != '0);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr] <= i_tx_byte;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // serialiser
  state_t      state;
  state_t      state_next;
  logic [3:0]  tcnt;
  logic [3:0]  tcnt_next;
  logic [2:0]  bidx;
  logic [2:0]  bidx_next;
  logic [7:0]  sh;
  logic [7:0]  sh_next;
  logic        tx;
  logic        tx_next;
  logic        bit_end;

  assign bit_end = tick && (tcnt == 4'd15);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= st_idle;
      tcnt  <= '0;
      bidx  <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      bidx  <= bidx_next;
      sh    <= sh_next;
      tx    <= tx_next;
    end
  end

  // tx_next follows the level of the state being entered, so o_tx changes
  // on the same edge as the state register
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    bidx_next  = bidx;
    sh_next    = sh;
    tx_next    = tx;
    pop        = 1'b0;

    if (tick && (state != st_idle)) begin
      tcnt_next = tcnt + 4'd1;
    end

    case (state)
      st_idle: begin
        tx_next = 1'b1;
        if (tick && fifo_nonempty) begin
          pop        = 1'b1;
          sh_next    = mem[rptr];
          tcnt_next  = 4'd0;
          state_next = st_start;
          tx_next    = 1'b0;
        end
      end
      st_start: begin
        if (bit_end) begin
          state_next = st_data;
          bidx_next  = 3'd0;
          tx_next    = sh[0];
        end
      end
      st_data: begin
        if (bit_end) begin
          if (bidx == 3'd7) begin
            state_next = st_stop;
            tx_next    = 1'b1;
          end else begin
            sh_next   = {1'b0, sh[7:1]};
            bidx_next = bidx + 3'd1;
            tx_next   = sh[1];
          end
        end
      end
      st_stop: begin
        if (bit_end) begin
          // a queued byte starts on this same tick, leaving no idle gap
          if (fifo_nonempty) begin
            pop        = 1'b1;
            sh_next    = mem[rptr];
            state_next = st_start;
            tx_next    = 1'b0;
          end else begin
            state_next = st_idle;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = st_idle;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign o_tx         = tx;
  assign o_busy       = (state != st_idle) || fifo_nonempty;
  assign o_fifo_count = count;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the debug port. It is the transmit counterpart of the existing `uart` receiver and sends 8N1 frames on the FTDI RX pin, so the board can report bytes back to the host. Bytes enter through a valid/ready handshake into an internal FIFO. A fractional baud accumulator, configured the same way as the receiver's, paces the serialiser. Typical top-level use is `o_tx -> ftdi_rxd`, fed by a status or echo source.

## Interface
- `baud_acc_width`, default 11: width of the baud accumulator. Its carry-out is the 16x oversample tick.
- `baud_acc_incr`, default 151: added to the accumulator every clock. With a 25 MHz clock this gives 16 x 115200 Hz.
- `fifo_depth_log2`, default 4: FIFO holds 2^`fifo_depth_log2` bytes.
- `i_clk` input 1: single clock.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_tx_byte` input 8: byte to enqueue.
- `i_tx_valid` input 1: `i_tx_byte` is valid this cycle.
- `o_tx_ready` output 1: FIFO not full, so a write is accepted.
- `o_tx` output 1: serial line, idle high. Registered.
- `o_busy` output 1: FIFO non-empty or a frame in progress.
- `o_fifo_count` output `fifo_depth_log2`+1: number of bytes queued, excluding the byte being shifted.

## Operation
- **Baud tick**
  - Each clock: `{carry, acc} <= acc + baud_acc_incr`, computed `baud_acc_width`+1 bits wide.
  - `tick` = carry. It runs continuously and is never reset by frame activity.
- **Bit period**: a 4-bit counter `tcnt` advances on each `tick`. One bit lasts 16 ticks, and a state ends on the tick where `tcnt` wraps 15 -> 0.
- **Write side**
  - A push occurs when `i_tx_valid && o_tx_ready` at the clock edge.
  - `o_tx_ready` = count < depth. It depends only on the current count, so a full FIFO rejects a write even when a pop happens in the same cycle.
  - `i_tx_valid` with `o_tx_ready` low is ignored: no change, no error flag.
- **FSM states**: IDLE, START, DATA, STOP.
  - **IDLE**
    - `o_tx`=1.
    - On a `tick` with the FIFO non-empty: pop into shift register `sh`, set `tcnt`=0, go to START.
  - **START**
    - `o_tx`=0 for 16 ticks.
    - Then go to DATA with bit index `bidx`=0.
  - **DATA**
    - `o_tx`=`sh[0]`, so bits go out LSB first.
    - At the end of each bit period: shift `sh` right and `bidx`++.
    - After `bidx`=7 completes, go to STOP.
  - **STOP**
    - `o_tx`=1 for 16 ticks.
    - At the end: if the FIFO is non-empty, pop and go directly to START on the same tick (no idle gap). Otherwise go to IDLE.
- **FIFO**
  - Circular buffer with `fifo_depth_log2`-bit read/write pointers that wrap modulo depth.
  - Count is tracked separately.
  - Simultaneous push and pop (FIFO not full) leaves the count unchanged; both pointers advance.
  - Pop from an empty FIFO never occurs, because the FSM checks the count.
- **`o_busy`** = (state != IDLE) || (count != 0).

## Timing
- **Reset** (async assert; deassert synchronised by the existing top-level practice):
  - `acc`=0, `tcnt`=0, state=IDLE, pointers=0.
  - Outputs: `o_tx`=1, `o_tx_ready`=1, `o_busy`=0, `o_fifo_count`=0.
  - Reset mid-frame aborts the frame. `o_tx` returns high asynchronously and queued bytes are discarded.
- **Push timing**
  - `o_fifo_count` increments the cycle after an accepted push.
  - `o_busy` rises the cycle after the first push.
- **Start-bit latency**: from push to `o_tx` falling is 1 to (2^`baud_acc_width`/`baud_acc_incr` + 2) clocks, because the FSM waits for the next tick.
- **Frame length**
  - Exactly 160 ticks (10 bits), measured from the start-bit falling edge to the end of the stop bit.
  - At the defaults, one bit is about 217 clocks, with tick jitter of ±1 clock; the error from 115200 baud is 0.0033%.
- **Back-to-back frames**: consecutive queued bytes go out with zero idle ticks between the stop bit and the next start bit.
- **`o_busy` fall**: the cycle after STOP ends with an empty FIFO.

## Test plan
All scenarios use the bench parameters `baud_acc_width`=4, `baud_acc_incr`=8 (tick every 2 clocks, bit = 32 clocks), `fifo_depth_log2`=2.
- **Single byte**
  - Stimulus: push 0xA5.
  - Required response: `o_tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1. Each level holds 32 clocks ±1, and `o_busy` falls 1 clock after the stop bit ends.
- **Fill and overflow**
  - Stimulus: push 0x01..0x06 on consecutive cycles while the line is idle.
  - Required response: first byte is popped; 0x02..0x05 fill the FIFO; `o_tx_ready`=0 when 0x06 is offered; 0x06 is dropped. Line output is 0x01..0x05 back-to-back, with no high gap longer than the 32-clock stop bit.
- **Push and pop in the same cycle**
  - Stimulus: hold `i_tx_valid` high with an incrementing byte while the FIFO holds 2 bytes, so that a push lands on the cycle the FSM pops.
  - Required response: `o_fifo_count` stays at 2 across that edge, and byte order is preserved.
- **Reset mid-frame**
  - Stimulus: assert `i_rst_n`=0 during DATA bit 3 of 0x00.
  - Required response: `o_tx`=1 within the same cycle (asynchronous); after release, count=0, `o_busy`=0, and no further frame is sent.
- **Default-rate check**
  - Stimulus: default parameters at 25 MHz; send 0x55.
  - Required response: frame lasts 2170 ±2 clocks from the start-bit falling edge to the end of the stop bit.
- **Loopback**
  - Stimulus: `o_tx` connected to the existing `uart` receiver (same parameters); send 0x00, 0xFF, 0x3C.
  - Required response: the receiver reports identical bytes in order.
